// File: rtl/status_evt_pkg.sv
// status_evt_pkg
//   Shared constants, types and helpers for the status event capture path.
//   STATUS_W      : default status word width, must match the upstream
//                   input_status word.
//   EVT_TS_W      : default timestamp width.
//   status_evt_t  : one captured event {status, ts[, parity]}.
//   cnt_w()       : width needed to hold an occupancy count of 0..depth.
//   Optional macro STATUS_EVT_PARITY_EN adds the parity field to status_evt_t.
package status_evt_pkg;

    localparam int STATUS_W = 9;
    localparam int EVT_TS_W = 16;

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        logic [EVT_TS_W-1:0] ts;
`ifdef STATUS_EVT_PARITY_EN
        logic                parity;
`endif
    } status_evt_t;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/status_debounce.sv
// status_debounce
//   Debounces a multi-bit status word. A value must be sampled on
//   STABLE_CYCLES consecutive edges before it is committed. o_commit strobes
//   combinationally during the cycle whose edge commits a new value, so the
//   consumer can capture o_commit_val on that same edge.
// Ports:
//   sysclk        in  clock, rising edge
//   reset         in  asynchronous active-low reset
//   status_in     in  raw status word, may glitch
//   o_commit      out commit strobe (valid for the upcoming edge)
//   o_commit_val  out value being committed when o_commit is high
module status_debounce
    import status_evt_pkg::*;
#(
    parameter int W             = STATUS_W,
    parameter int STABLE_CYCLES = 4
)(
    input  logic         sysclk,
    input  logic         reset,
    input  logic [W-1:0] status_in,
    output logic         o_commit,
    output logic [W-1:0] o_commit_val
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [W-1:0]  r_candidate;
    logic [W-1:0]  r_committed;
    logic [CW-1:0] r_cnt;

    logic [W-1:0]  w_cand_nxt;
    logic [CW-1:0] w_cnt_nxt;

    // Next-state view lets STABLE_CYCLES=1 commit on the very first
    // differing sample.
    always_comb begin
        w_cand_nxt = r_candidate;
        w_cnt_nxt  = r_cnt;
        if (status_in != r_candidate) begin
            w_cand_nxt = status_in;
            w_cnt_nxt  = CW'(1);
        end else if (r_cnt < CW'(STABLE_CYCLES)) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    // Once saturated, candidate already equals committed, so a held value
    // commits exactly once.
    assign o_commit     = (w_cnt_nxt == CW'(STABLE_CYCLES)) && (w_cand_nxt != r_committed);
    assign o_commit_val = w_cand_nxt;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_candidate <= '0;
            r_committed <= '0;
            r_cnt       <= '0;
        end else begin
            r_candidate <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            if (o_commit) r_committed <= w_cand_nxt;
        end
    end

endmodule

// File: rtl/status_event_capture.sv
// status_event_capture
//   Debounces the status word, timestamps each committed change and buffers
//   it in a first-word-fall-through FIFO drained over a valid/ready port.
//   A sticky overflow flag records events dropped on a full FIFO.
// Ports:
//   sysclk        in  clock, rising edge
//   reset         in  asynchronous active-low reset
//   status_in     in  raw status word
//   evt_valid     out FIFO head holds an event (registered)
//   evt_ready     in  consumer accepts head; pop = evt_valid && evt_ready
//   evt_status    out committed status of head event (registered)
//   evt_ts        out timestamp of head event (registered)
//   evt_count     out events held
//   overflow      out sticky drop flag
//   clr_overflow  in  clears overflow (a simultaneous drop wins)
//   evt_parity    out even parity over {evt_status, evt_ts}; only present
//                     when STATUS_EVT_PARITY_EN is defined
module status_event_capture
    import status_evt_pkg::*;
#(
    parameter int W             = STATUS_W,
    parameter int DEPTH         = 8,
    parameter int STABLE_CYCLES = 4,
    parameter int TS_W          = EVT_TS_W
)(
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic [W-1:0]              status_in,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [W-1:0]              evt_status,
    output logic [TS_W-1:0]           evt_ts,
    output logic [cnt_w(DEPTH)-1:0]   evt_count,
    output logic                      overflow,
`ifdef STATUS_EVT_PARITY_EN
    output logic                      evt_parity,
`endif
    input  logic                      clr_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic             w_commit;
    logic [W-1:0]     w_commit_val;

    status_debounce #(
        .W             (W),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_debounce (
        .sysclk       (sysclk),
        .reset        (reset),
        .status_in    (status_in),
        .o_commit     (w_commit),
        .o_commit_val (w_commit_val)
    );

    logic [W-1:0]     r_mem_st [DEPTH];
    logic [TS_W-1:0]  r_mem_ts [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [TS_W-1:0]  r_ts;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rptr_nxt;
    logic             w_head_from_push;

    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_pop       = evt_valid && evt_ready;
    // A pop frees the slot on the same edge, so push while full is fine then.
    assign w_push      = w_commit && (!w_full || w_pop);
    assign w_drop      = w_commit && w_full && !w_pop;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rptr_nxt  = r_rptr + PTR_W'(w_pop);
    // Nothing older survives this edge: the pushed entry becomes the head.
    assign w_head_from_push = (r_count == CNT_W'(w_pop));

    assign evt_count = r_count;

`ifdef STATUS_EVT_PARITY_EN
    logic             r_mem_par [DEPTH];
    logic             w_par;
    assign w_par = ^{w_commit_val, r_ts};
`endif

    // Storage array
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_st[i] <= '0;
                r_mem_ts[i] <= '0;
`ifdef STATUS_EVT_PARITY_EN
                r_mem_par[i] <= 1'b0;
`endif
            end
        end else if (w_push) begin
            r_mem_st[r_wptr] <= w_commit_val;
            r_mem_ts[r_wptr] <= r_ts;
`ifdef STATUS_EVT_PARITY_EN
            r_mem_par[r_wptr] <= w_par;
`endif
        end
    end

    // Pointers, count, timestamp, registered head, overflow
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_ts       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            evt_valid  <= 1'b0;
            evt_status <= '0;
            evt_ts     <= '0;
            overflow   <= 1'b0;
`ifdef STATUS_EVT_PARITY_EN
            evt_parity <= 1'b0;
`endif
        end else begin
            r_ts      <= r_ts + TS_W'(1);
            r_wptr    <= r_wptr + PTR_W'(w_push);
            r_rptr    <= w_rptr_nxt;
            r_count   <= w_count_nxt;
            evt_valid <= (w_count_nxt != '0);
            // Head registers hold their last value when the FIFO drains empty.
            if (w_count_nxt != '0) begin
                if (w_head_from_push) begin
                    evt_status <= w_commit_val;
                    evt_ts     <= r_ts;
`ifdef STATUS_EVT_PARITY_EN
                    evt_parity <= w_par;
`endif
                end else begin
                    evt_status <= r_mem_st[w_rptr_nxt];
                    evt_ts     <= r_mem_ts[w_rptr_nxt];
`ifdef STATUS_EVT_PARITY_EN
                    evt_parity <= r_mem_par[w_rptr_nxt];
`endif
                end
            end
            if (w_drop)            overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: doc/status_event_capture.md
Name: status_event_capture

Overview:
- Downstream consumer of the 9-bit input-status word built by the status-combine stage.
- Debounces the word and detects committed changes.
- Timestamps each committed change and buffers it in a small FIFO.
- A valid/ready port drains events to the host/debug logic; a sticky overflow flag records lost events.

Parameters:
- W, 9: status word width; must match the upstream input_status width.
- DEPTH, 8: FIFO entries; power of two, >= 2.
- STABLE_CYCLES, 4: consecutive identical samples needed to commit a value; >= 1.
- TS_W, 16: timestamp counter width.

Ports:
- sysclk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- status_in  in  W  raw status word from the upstream stage; may glitch.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head; a pop occurs when evt_valid && evt_ready.
- evt_status  out  W  committed status value of the head event.
- evt_ts  out  TS_W  timestamp of the head event.
- evt_count  out  clog2(DEPTH+1)  number of events held.
- overflow  out  1  sticky: an event was dropped.
- clr_overflow  in  1  one-cycle pulse that clears overflow.

Behaviour:
Reset (reset low):
- Clears all state immediately.
- Outputs: evt_valid=0, evt_status=0, evt_ts=0, evt_count=0, overflow=0.
- Internal state: committed=0, candidate=0, stable count=0, ts=0.
- Status word 0 at reset produces no event.
- Asserting reset mid-operation discards buffered events with no drain.

Timestamp:
- ts increments every cycle and wraps 2^TS_W-1 -> 0.
- An event records ts as sampled on the push edge, i.e. the pre-increment value.

Debounce:
- candidate tracks status_in.
- A sample differing from candidate reloads candidate and restarts the stability count at 1.
- An equal sample increments the count, saturating at STABLE_CYCLES.
- Push condition: the edge at which the count reaches STABLE_CYCLES and candidate != committed.
  - That edge sets committed := candidate and pushes {candidate, ts}.
- A value held indefinitely pushes exactly once.
- A glitch shorter than STABLE_CYCLES edges pushes nothing.
- A return to the committed value before it commits pushes nothing.
- STABLE_CYCLES=1 means no debounce: the first differing sample pushes on that edge.

FIFO:
- First-word-fall-through.
- evt_valid, evt_status and evt_ts are registered state, reflecting the head from the edge after the push into an empty FIFO.
- Latency from the first sampling edge of a new stable value to evt_valid=1 is STABLE_CYCLES edges.
- Pointers wrap modulo DEPTH.
- evt_status and evt_ts hold the last value when empty (don't-care; benches must not check them).

Boundary conditions:
- Push and pop in the same cycle:
  - Always legal, including when full; count is unchanged.
  - When empty, the pop is ignored (evt_valid=0) and the push lands.
- Push when full with no pop:
  - The event is dropped.
  - committed still updates, so no repeat event is generated.
  - overflow <= 1.
- clr_overflow in the same cycle as a new drop: overflow stays 1 (set wins).
- evt_ready while empty: ignored.

Optional Feature:
- Macro: STATUS_EVT_PARITY_EN.
- Defined:
  - Adds output evt_parity (1 bit) = even parity over {evt_status, evt_ts}.
  - Parity is computed at push and stored in the FIFO entry; reset value 0.
- Undefined:
  - Port absent.
  - Entry width is W+TS_W.
  - No other behaviour changes.

Decomposition:
- Package status_evt_pkg holds:
  - the W default constant;
  - typedef status_evt_t (status[W-1:0], ts[TS_W-1:0], optional parity);
  - the clog2-based count-width function.
- Sub-module status_debounce:
  - Ports: sysclk, reset, status_in, stable/commit strobe, committed value.
  - Reusable by other status paths.
- The FIFO stays inline in the top.

Test Plan:
1. Reset release with status_in=0 held 20 cycles -> evt_valid=0, evt_count=0, overflow=0 throughout.
2. status_in 0x000 -> 0x1A5 held 10 cycles with STABLE_CYCLES=4, evt_ready=0 -> exactly one event, evt_status=0x1A5 valid 4 edges after the first sampling edge; evt_ts = ts at that push.
3. 3-cycle glitch to 0x0FF, then back to 0x1A5 -> no new event; evt_count unchanged.
4. Ten distinct stable values, each held 5 cycles, with evt_ready=0 and DEPTH=8:
   - evt_count saturates at 8 and overflow=1.
   - Draining yields the first 8 values in order.
   - clr_overflow then clears overflow.
5. FIFO full; a new value commits on the same edge as a pop -> count stays 8, no overflow, the new event appears last.
6. Reset asserted with 3 events buffered and evt_valid=1 -> all outputs 0 asynchronously; after release no stale events appear.
